vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with a pixel-fetch interface and aligned RGB output. It replaces the fixed 640x480 generator. Timing, sync polarity, pixel-clock division and colour depth are set by parameters. It requests pixels from an upstream frame source by coordinate and drives the VGA connector pins with `rgb`, `hsync`, `vsync` and `de` aligned to each other.

---
 rtl/vga_timing_gen_if.sv | 13 +
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-fetch bus between the VGA timing generator (master) and its upstream frame source (slave).
interface vga_timing_gen_if #(
    parameter int CNT_W   = 11,
    parameter int COLOR_W = 6
);
    logic [CNT_W-1:0]   pix_x;
    logic [CNT_W-1:0]   pix_y;
    logic               pix_req;
    logic [COLOR_W-1:0] pix_data;

    modport master (output pix_x, output pix_y, output pix_req, input pix_data);
    modport slave  (input pix_x, input pix_y, input pix_req, output pix_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel fetch by coordinate, 2-tick aligned rgb/hsync/vsync/de.
// Optional colour-bar test pattern is built only when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 6,
    parameter int CNT_W    = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                test_en,
    vga_timing_gen_if.master    fetch,
    output logic [COLOR_W-1:0]  rgb,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic                frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
    logic               pix_tick, hactive, vactive, hs0, vs0;

    // Stage 1: request coordinates plus decoded flags carried alongside them.
    logic [CNT_W-1:0]   pix_x_q, pix_y_q;
    logic               pix_req_q, de1_q, hs1_q, vs1_q, fs1_q;

    logic [COLOR_W-1:0] pixel, rgb_d, rgb_q;
    logic               de_q, hsync_q, vsync_q, frame_start_q;

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        pix_tick  = en && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        if (en) begin
            div_cnt_d = pix_tick ? '0 : div_cnt_q + 1'b1;
        end
        h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
        hactive = (h_q < H_ACT);
        vactive = (v_q < V_ACT);
        hs0     = (h_q >= HS_BEG) && (h_q < HS_END);
        vs0     = (v_q >= VS_BEG) && (v_q < VS_END);
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [CNT_W+2:0] x_times8;
    logic [2:0]       bar_idx;

    // Eight equal-width bars; the 3-bit bar index is replicated MSB-first across the colour word.
    always_comb begin
        x_times8 = {pix_x_q, 3'b000};
        bar_idx  = 3'(x_times8 / (CNT_W + 3)'(H_ACTIVE));
        pixel    = fetch.pix_data;
        if (test_en) begin
            for (int i = 0; i < COLOR_W; i++) begin
                pixel[COLOR_W-1-i] = bar_idx[2 - (i % 3)];
            end
        end
    end
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign pixel          = fetch.pix_data;
`endif

    assign rgb_d = de1_q ? pixel : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            h_q           <= '0;
            v_q           <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_req_q     <= 1'b0;
            de1_q         <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            fs1_q         <= 1'b0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            frame_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the pre-edge value of the one before it.
            div_cnt_q     <= div_cnt_d;
            frame_start_q <= pix_tick && fs1_q;
            if (pix_tick) begin
                h_q       <= h_d;
                v_q       <= v_d;
                pix_x_q   <= h_q;
                pix_y_q   <= v_q;
                pix_req_q <= hactive && vactive;
                de1_q     <= hactive && vactive;
                hs1_q     <= hs0;
                vs1_q     <= vs0;
                fs1_q     <= (h_q == '0) && (v_q == '0);
                rgb_q     <= rgb_d;
                de_q      <= de1_q;
                hsync_q   <= hs1_q ? HS_POL : ~HS_POL;
                vsync_q   <= vs1_q ? VS_POL : ~VS_POL;
            end
        end
    end

    assign fetch.pix_x   = pix_x_q;
    assign fetch.pix_y   = pix_y_q;
    assign fetch.pix_req = pix_req_q;
    assign rgb           = rgb_q;
    assign de            = de_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign frame_start   = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 14x7 rasters (CLK_DIV 1 and 2, both sync polarities) plus a default 640x480 instance.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;
    logic en_p;
    logic test_en;

    always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    // Small raster, CLK_DIV=1, active-low syncs.
    vga_timing_gen_if #(.CNT_W(11), .COLOR_W(6)) if_s ();
    logic [5:0] s_rgb;
    logic       s_hsync, s_vsync, s_de, s_fs;
    assign if_s.pix_data = {if_s.pix_x[2:0], if_s.pix_y[2:0]};

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .COLOR_W(6), .CNT_W(11)
    ) dut_s (
        .clk(clk), .rst(rst), .en(1'b1), .test_en(test_en), .fetch(if_s),
        .rgb(s_rgb), .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .frame_start(s_fs)
    );

    // Same raster, CLK_DIV=2, active-high syncs, gated enable.
    vga_timing_gen_if #(.CNT_W(11), .COLOR_W(6)) if_p ();
    logic [5:0] p_rgb;
    logic       p_hsync, p_vsync, p_de, p_fs;
    assign if_p.pix_data = {if_p.pix_x[2:0], if_p.pix_y[2:0]};

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2), .COLOR_W(6), .CNT_W(11)
    ) dut_p (
        .clk(clk), .rst(rst), .en(en_p), .test_en(test_en), .fetch(if_p),
        .rgb(p_rgb), .hsync(p_hsync), .vsync(p_vsync), .de(p_de), .frame_start(p_fs)
    );

    // Default 640x480 raster; only line timing is measured.
    vga_timing_gen_if #(.CNT_W(11), .COLOR_W(6)) if_d ();
    logic [5:0] d_rgb;
    logic       d_hsync, d_vsync, d_de, d_fs;
    assign if_d.pix_data = 6'd0;

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .en(1'b1), .test_en(1'b0), .fetch(if_d),
        .rgb(d_rgb), .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .frame_start(d_fs)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: k ticks since reset release; stage 1 holds counter index k-1, stage 2 holds k-2.
    task automatic check_raster(input string dn, input int k, input bit tick, input bit pol, input bit pat,
                                input logic [10:0] px, input logic [10:0] py, input logic req,
                                input logic [5:0] rgb_v, input logic hs, input logic vs,
                                input logic de_v, input logic fs);
        int       h, v;
        bit       de_e, hs_a, vs_a, fs_e;
        logic [2:0] h3, v3;
        logic [5:0] rgb_e;
        if (k < 1) begin
            check({dn, "_pix_x"},   32'(px),  32'd0);
            check({dn, "_pix_y"},   32'(py),  32'd0);
            check({dn, "_pix_req"}, 32'(req), 32'd0);
        end else begin
            h = (k - 1) % 14;
            v = ((k - 1) / 14) % 7;
            check({dn, "_pix_x"},   32'(px),  32'(h));
            check({dn, "_pix_y"},   32'(py),  32'(v));
            check({dn, "_pix_req"}, 32'(req), 32'(h < 8 && v < 4));
        end
        de_e  = 1'b0;
        hs_a  = 1'b0;
        vs_a  = 1'b0;
        fs_e  = 1'b0;
        rgb_e = 6'd0;
        if (k >= 2) begin
            h    = (k - 2) % 14;
            v    = ((k - 2) / 14) % 7;
            h3   = 3'(h);
            v3   = 3'(v);
            de_e = (h < 8) && (v < 4);
            hs_a = (h == 10) || (h == 11);
            vs_a = (v == 5);
            fs_e = tick && (h == 0) && (v == 0);
            if (de_e) rgb_e = pat ? {h3, h3} : {h3, v3};
        end
        check({dn, "_rgb"},         32'(rgb_v), 32'(rgb_e));
        check({dn, "_de"},          32'(de_v),  32'(de_e));
        check({dn, "_hsync"},       32'(hs),    32'(pol ? hs_a : !hs_a));
        check({dn, "_vsync"},       32'(vs),    32'(pol ? vs_a : !vs_a));
        check({dn, "_frame_start"}, 32'(fs),    32'(fs_e));
    endtask

    task automatic check_reset(input string dn, input bit pol,
                               input logic [10:0] px, input logic [10:0] py, input logic req,
                               input logic [5:0] rgb_v, input logic hs, input logic vs,
                               input logic de_v, input logic fs);
        check({dn, "_rst_pix_x"},   32'(px),    32'd0);
        check({dn, "_rst_pix_y"},   32'(py),    32'd0);
        check({dn, "_rst_pix_req"}, 32'(req),   32'd0);
        check({dn, "_rst_rgb"},     32'(rgb_v), 32'd0);
        check({dn, "_rst_de"},      32'(de_v),  32'd0);
        check({dn, "_rst_fs"},      32'(fs),    32'd0);
        check({dn, "_rst_hsync"},   32'(hs),    32'(!pol));
        check({dn, "_rst_vsync"},   32'(vs),    32'(!pol));
    endtask

    // Reference tick bookkeeping, updated from the stimulus side only.
    int ks, ep, drop_left;
    bit tick_p, dropped;
    int fs_s0, fs_s1, fs_p0, fs_p1;

    task automatic run(input int n, input bit pat);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            ks++;
            if (en_p) begin
                ep++;
                tick_p = (ep % 2 == 0);
            end else begin
                tick_p = 1'b0;
            end
            @(negedge clk);
            check_raster("s", ks, 1'b1, 1'b0, pat, if_s.pix_x, if_s.pix_y, if_s.pix_req,
                         s_rgb, s_hsync, s_vsync, s_de, s_fs);
            check_raster("p", ep / 2, tick_p, 1'b1, pat, if_p.pix_x, if_p.pix_y, if_p.pix_req,
                         p_rgb, p_hsync, p_vsync, p_de, p_fs);
            if (s_fs === 1'b1) begin
                if (fs_s0 < 0) fs_s0 = c; else if (fs_s1 < 0) fs_s1 = c;
            end
            if (p_fs === 1'b1) begin
                if (fs_p0 < 0) fs_p0 = c; else if (fs_p1 < 0) fs_p1 = c;
            end
            // Drop en for 37 clk when stage 1 presents h=5 of line 1.
            if (!en_p) begin
                drop_left--;
                if (drop_left == 0) en_p = 1'b1;
            end else if (ep == 40 && !dropped) begin
                en_p      = 1'b0;
                drop_left = 37;
                dropped   = 1'b1;
            end
        end
    endtask

    // Default-raster hsync edge timestamps, in clk cycles after reset release.
    int   cyc_d = 0;
    int   d_f1 = -1, d_f2 = -1, d_r1 = -1;
    logic d_hs_prev = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                cyc_d++;
                if (d_hs_prev && !d_hsync) begin
                    if (d_f1 < 0) d_f1 = cyc_d; else if (d_f2 < 0) d_f2 = cyc_d;
                end
                if (!d_hs_prev && d_hsync && d_f1 >= 0 && d_r1 < 0) d_r1 = cyc_d;
            end
            d_hs_prev = d_hsync;
        end
    end

    initial begin
        rst     = 1'b0;
        en_p    = 1'b1;
        test_en = 1'b0;
        ks = 0; ep = 0; drop_left = 0; tick_p = 1'b0; dropped = 1'b0;
        fs_s0 = -1; fs_s1 = -1; fs_p0 = -1; fs_p1 = -1;

        repeat (3) @(negedge clk);
        check_reset("s", 1'b0, if_s.pix_x, if_s.pix_y, if_s.pix_req, s_rgb, s_hsync, s_vsync, s_de, s_fs);
        check_reset("p", 1'b1, if_p.pix_x, if_p.pix_y, if_p.pix_req, p_rgb, p_hsync, p_vsync, p_de, p_fs);
        check_reset("d", 1'b0, if_d.pix_x, if_d.pix_y, if_d.pix_req, d_rgb, d_hsync, d_vsync, d_de, d_fs);

        #1 rst = 1'b1;
        run(3000, 1'b0);

        check("s_fs_first",  32'(fs_s0), 32'd2);
        check("s_fs_second", 32'(fs_s1), 32'd100);
        check("p_fs_first",  32'(fs_p0), 32'd4);
        check("p_fs_period_with_stall", 32'(fs_p1 - fs_p0), 32'd233);
        check("d_hsync_first_fall", 32'(d_f1), 32'd1316);
        check("d_hsync_low_width",  32'(d_r1 - d_f1), 32'd192);
        check("d_line_period",      32'(d_f2 - d_f1), 32'd1600);

        // Asynchronous reset in the middle of a frame.
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_reset("s_mid", 1'b0, if_s.pix_x, if_s.pix_y, if_s.pix_req, s_rgb, s_hsync, s_vsync, s_de, s_fs);
        check_reset("p_mid", 1'b1, if_p.pix_x, if_p.pix_y, if_p.pix_req, p_rgb, p_hsync, p_vsync, p_de, p_fs);
        check("d_mid_hsync", 32'(d_hsync), 32'd1);
        check("d_mid_de",    32'(d_de),    32'd0);

        test_en = 1'b1;
        @(negedge clk);
        ks = 0; ep = 0; tick_p = 1'b0;
        fs_s0 = -1; fs_s1 = -1; fs_p0 = -1; fs_p1 = -1;
        #1 rst = 1'b1;
        run(300, PAT);
        check("s_fs_after_rst", 32'(fs_s0), 32'd2);
        check("p_fs_after_rst", 32'(fs_p0), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
